// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file widths, load-return entry and writeback select types
//
// Purpose: common definitions for the writeback write-port controller and its load FIFO.
// Contents: XLEN, AW, NUM_REGS, LOAD_FIFO_DEPTH, wb_entry_t {live, rd, data}, wb_sel_e.
package riscv_pkg;

   localparam int XLEN            = 32;
   localparam int AW              = 5;
   localparam int NUM_REGS        = 2 ** AW;
   localparam int LOAD_FIFO_DEPTH = 4;

   // One queued load return; live drops when a younger ALU write to the same rd wins.
   typedef struct packed {
      logic            live;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

   // Which producer owns the write port in the current cycle.
   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_ALU   = 2'd1,
      WB_DRAIN = 2'd2
   } wb_sel_e;

endpackage

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - circular load-return buffer with kill-by-rd and pending mask
//
// Purpose: holds accepted load returns in arrival order until the write port is free.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   push_i, push_rd_i/_data_i   enqueue one live entry at the tail (ignored when full)
//   pop_i                       consume the head entry (ignored when empty)
//   kill_i, kill_rd_i           clear live on every queued entry targeting kill_rd_i
//   head_live_o/_rd_o/_data_o   current head entry
//   empty_o, full_o, count_o    occupancy
//   pending_mask_o              one-hot OR of rd over live entries
module wb_load_fifo #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [AW-1:0]            push_rd_i,
   input  logic [XLEN-1:0]          push_data_i,
   input  logic                     pop_i,
   input  logic                     kill_i,
   input  logic [AW-1:0]            kill_rd_i,
   output logic                     head_live_o,
   output logic [AW-1:0]            head_rd_o,
   output logic [XLEN-1:0]          head_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [(2**AW)-1:0]       pending_mask_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]   head_q;
   logic [PW-1:0]   tail_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] live_q;
   logic [AW-1:0]   rd_q   [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];

   logic push_eff;
   logic pop_eff;

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == CW'(DEPTH));
   assign push_eff = push_i && !full_o;
   assign pop_eff  = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      case ({push_eff, pop_eff})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Kill is applied first, then pop and push; the pushed slot is never occupied,
   // so a load arriving alongside the killing ALU write stays live.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         live_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && live_q[i] && (rd_q[i] == kill_rd_i)) begin
               live_q[i] <= 1'b0;
            end
         end
         if (pop_eff) begin
            valid_q[head_q] <= 1'b0;
            live_q[head_q]  <= 1'b0;
            head_q          <= head_q + PW'(1);
         end
         if (push_eff) begin
            valid_q[tail_q] <= 1'b1;
            live_q[tail_q]  <= 1'b1;
            tail_q          <= tail_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   // Payload needs no reset: valid/live gate every use of it.
   always_ff @(posedge clk) begin
      if (push_eff) begin
         rd_q[tail_q]   <= push_rd_i;
         data_q[tail_q] <= push_data_i;
      end
   end

   always_comb begin
      pending_mask_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && live_q[i]) begin
            pending_mask_o[rd_q[i]] = 1'b1;
         end
      end
   end

   assign head_live_o = valid_q[head_q] && live_q[head_q];
   assign head_rd_o   = rd_q[head_q];
   assign head_data_o = data_q[head_q];
   assign count_o     = count_q;

endmodule

// File: rtl/wb_write_port_ctrl.sv
// rtl/wb_write_port_ctrl.sv - register-file write-port arbiter for ALU results and load returns
//
// Purpose: ALU results take the write port immediately; load returns are queued and
// drained in cycles the ALU leaves free. Writes to x0 are dropped.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data        single-cycle ALU result, never stalled
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  load-return handshake into the FIFO
//   wr_en/wr_addr/wr_data            registered register-file write port
//   pending_mask                     registers targeted by live queued loads
//   fifo_count                       load FIFO occupancy
module wb_write_port_ctrl #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [AW-1:0]            lsu_rd,
   input  logic [XLEN-1:0]          lsu_data,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic [XLEN-1:0]          wr_data,
   output logic [(2**AW)-1:0]       pending_mask,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   import riscv_pkg::*;

   logic            alu_wr;
   logic            lsu_push;
   logic            fifo_pop;
   logic            fifo_empty;
   logic            fifo_full;
   logic            head_live;
   logic [AW-1:0]   head_rd;
   logic [XLEN-1:0] head_data;
   wb_sel_e         sel;

   logic            wr_en_q,   wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;

   assign alu_wr    = alu_valid && (alu_rd != '0);
   assign lsu_ready = !fifo_full;
   // rd==0 loads complete the handshake but are never stored.
   assign lsu_push  = lsu_valid && lsu_ready && (lsu_rd != '0);
   assign fifo_pop  = (sel == WB_DRAIN);

   wb_load_fifo #(
      .XLEN  (XLEN),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push_i         (lsu_push),
      .push_rd_i      (lsu_rd),
      .push_data_i    (lsu_data),
      .pop_i          (fifo_pop),
      .kill_i         (alu_wr),
      .kill_rd_i      (alu_rd),
      .head_live_o    (head_live),
      .head_rd_o      (head_rd),
      .head_data_o    (head_data),
      .empty_o        (fifo_empty),
      .full_o         (fifo_full),
      .count_o        (fifo_count),
      .pending_mask_o (pending_mask)
   );

   always_comb begin
      sel = WB_IDLE;
      if (alu_wr) begin
         sel = WB_ALU;
      end else if (!fifo_empty) begin
         sel = WB_DRAIN;
      end
   end

   // A killed head still consumes its drain slot but produces no write.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (sel)
         WB_ALU: begin
            wr_en_d   = 1'b1;
            wr_addr_d = alu_rd;
            wr_data_d = alu_data;
         end
         WB_DRAIN: begin
            if (head_live) begin
               wr_en_d   = 1'b1;
               wr_addr_d = head_rd;
               wr_data_d = head_data;
            end
         end
         default: begin
            wr_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// tb/tb_wb_write_port_ctrl.sv - self-checking bench for wb_write_port_ctrl
module tb_wb_write_port_ctrl;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pending_mask;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   wb_write_port_ctrl #(.XLEN(32), .AW(5), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .pending_mask (pending_mask),
      .fifo_count   (fifo_count)
   );

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t       sb[$];
   wb_entry_t mq[$];
   bit        acc;

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        en;
      logic [4:0]  ea;
      logic [31:0] ed;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
      foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
      return m;
   endfunction

   task automatic idle();
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      lsu_valid = 1'b0;
      lsu_rd    = '0;
      lsu_data  = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: predict this edge's write and queue effect from the driven inputs.
   task automatic step();
      bit        alu_w;
      bit        rdy;
      wb_entry_t h;
      alu_w = alu_valid && (alu_rd != 5'd0);
      rdy   = (mq.size() < 4);
      chk("lsu_ready", 64'(lsu_ready), 64'(rdy));
      acc = lsu_valid && rdy;
      if (alu_w) begin
         sb.push_back('{a: alu_rd, d: alu_data});
         foreach (mq[i]) if (mq[i].live && mq[i].rd == alu_rd) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         if (h.live) sb.push_back('{a: h.rd, d: h.data});
      end
      if (acc && lsu_rd != 5'd0) mq.push_back('{live: 1'b1, rd: lsu_rd, data: lsu_data});
      cyc();
      chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
      chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && wr_en === 1'b1) begin
         wr_t e;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
         end else begin
            e = sb.pop_front();
            chk("sb_write", {27'd0, wr_addr, wr_data}, {27'd0, e.a, e.d});
         end
      end
   end

   initial begin
      int k;
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_mask", 64'(pending_mask), 64'd0);
      chk("rst_ready", 64'(lsu_ready), 64'd1);
      rst = 1'b0;

      // ALU path vectors: expected values are the registered outputs after the edge.
      vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
      vt[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd5,  32'hDEADBEEF};
      vt[2] = '{1'b0, 5'd7,  32'h0BADF00D, 1'b0, 5'd5,  32'hDEADBEEF};
      vt[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
      vt[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  32'h00000001};
      vt[5] = '{1'b1, 5'd1,  32'h00000002, 1'b1, 5'd1,  32'h00000002};
      for (int i = 0; i < 6; i++) begin
         alu_valid = vt[i].av;
         alu_rd    = vt[i].ard;
         alu_data  = vt[i].ad;
         step();
         chk($sformatf("vec%0d_wr_en", i), 64'(wr_en), 64'(vt[i].en));
         chk($sformatf("vec%0d_wr_addr", i), 64'(wr_addr), 64'(vt[i].ea));
         chk($sformatf("vec%0d_wr_data", i), 64'(wr_data), 64'(vt[i].ed));
      end
      idle();
      step();
      chk("alu_idle_wr_en", 64'(wr_en), 64'd0);

      // Load path with the ALU idle: enqueue, then pop one edge later.
      lsu_valid = 1'b1;
      lsu_rd    = 5'd6;
      lsu_data  = 32'hCAFEBABE;
      step();
      idle();
      chk("load_pending6", 64'(pending_mask[6]), 64'd1);
      chk("load_no_early_write", 64'(wr_en), 64'd0);
      step();
      chk("load_wr_en", 64'(wr_en), 64'd1);
      chk("load_wr_addr", 64'(wr_addr), 64'd6);
      chk("load_wr_data", 64'(wr_data), 64'hCAFEBABE);
      chk("load_pending6_clear", 64'(pending_mask[6]), 64'd0);
      step();

      // Contention: six ALU writes starve the FIFO while the LSU offers rd 7..12.
      k = 0;
      for (int c = 0; c < 6; c++) begin
         alu_valid = 1'b1;
         alu_rd    = 5'(20 + c);
         alu_data  = 32'hA0000000 + 32'(c);
         lsu_valid = (k < 6);
         lsu_rd    = 5'(7 + k);
         lsu_data  = 32'hB0000000 + 32'(7 + k);
         step();
         if (acc) k++;
      end
      chk("cont_ready_low", 64'(lsu_ready), 64'd0);
      chk("cont_count_full", 64'(fifo_count), 64'd4);
      for (int j = 0; j < 8; j++) begin
         alu_valid = 1'b0;
         lsu_valid = (k < 6);
         lsu_rd    = 5'(7 + k);
         lsu_data  = 32'hB0000000 + 32'(7 + k);
         step();
         if (acc) k++;
         if (j < 4) begin
            chk($sformatf("cont_drain%0d_en", j), 64'(wr_en), 64'd1);
            chk($sformatf("cont_drain%0d_addr", j), 64'(wr_addr), 64'(7 + j));
         end
         if (j == 0) chk("cont_ready_back", 64'(lsu_ready), 64'd1);
      end
      idle();
      step();
      chk("cont_sb_empty", 64'(sb.size()), 64'd0);

      // WAW kill: queued load to x9 is overtaken by an ALU write to x9.
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99999999;
      step();
      chk("waw_pending9", 64'(pending_mask[9]), 64'd1);
      idle();
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h11111111;
      step();
      chk("waw_killed_mask", 64'(pending_mask[9]), 64'd0);
      chk("waw_killed_count", 64'(fifo_count), 64'd1);
      chk("waw_alu_data", 64'(wr_data), 64'h11111111);
      idle();
      step();
      chk("waw_drain_no_write", 64'(wr_en), 64'd0);
      chk("waw_drain_count", 64'(fifo_count), 64'd0);
      // Same-cycle load is younger than the ALU write and must survive.
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h22222222;
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h44444444;
      step();
      chk("waw_young_pending", 64'(pending_mask[9]), 64'd1);
      idle();
      step();
      chk("waw_young_en", 64'(wr_en), 64'd1);
      chk("waw_young_data", 64'(wr_data), 64'h44444444);

      // Streaming loads: steady push/pop with pointer wrap.
      for (int i = 0; i < 10; i++) begin
         alu_valid = 1'b0;
         lsu_valid = 1'b1;
         lsu_rd    = 5'((i % 30) + 1);
         lsu_data  = $urandom;
         step();
         if (i >= 1) begin
            chk($sformatf("stream%0d_count", i), 64'(fifo_count), 64'd1);
            chk($sformatf("stream%0d_wr_en", i), 64'(wr_en), 64'd1);
         end
      end
      idle();
      step();
      chk("stream_last_en", 64'(wr_en), 64'd1);
      step();
      chk("stream_sb_empty", 64'(sb.size()), 64'd0);

      // Reset mid-drain with three entries still queued.
      for (int c = 0; c < 4; c++) begin
         alu_valid = 1'b1;
         alu_rd    = 5'(2 + c);
         alu_data  = 32'hC0000000 + 32'(c);
         lsu_valid = 1'b1;
         lsu_rd    = 5'(13 + c);
         lsu_data  = 32'hD0000000 + 32'(c);
         step();
      end
      idle();
      step();
      chk("pre_rst_count", 64'(fifo_count), 64'd3);
      chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
      chk("mid_rst_count", 64'(fifo_count), 64'd0);
      chk("mid_rst_mask", 64'(pending_mask), 64'd0);
      chk("mid_rst_ready", 64'(lsu_ready), 64'd1);
      sb.delete();
      mq.delete();
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("post_rst%0d_wr_en", i), 64'(wr_en), 64'd0);
      end
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
